// File: rtl/hcache_lookup_if.sv
// hcache_lookup_if: request/response, cache-port and backing-memory signals of the lookup controller.
interface hcache_lookup_if #(
    parameter int C_CACHE_MEM_ADDR_WIDTH = 32,
    parameter int C_CACHE_ADDR_WIDTH     = 13,
    parameter int C_CACHE_DATA_WIDTH     = 64
);
    localparam int TAG_W = C_CACHE_MEM_ADDR_WIDTH - C_CACHE_ADDR_WIDTH;
    logic                                  req_valid;
    logic                                  req_ready;
    logic [C_CACHE_MEM_ADDR_WIDTH-1:0]     req_addr;
    logic                                  rsp_valid;
    logic                                  rsp_ready;
    logic [C_CACHE_DATA_WIDTH-1:0]         rsp_data;
    logic                                  rsp_hit;
    logic                                  c_rd_en;
    logic [C_CACHE_ADDR_WIDTH-1:0]         c_rd_addr;
    logic [TAG_W-1:0]                      c_rd_din;
    logic                                  c_rd_result;
    logic [C_CACHE_DATA_WIDTH-1:0]         c_rd_dout;
    logic                                  c_rd_valid;
    logic                                  c_wr_en;
    logic [C_CACHE_ADDR_WIDTH-1:0]         c_wr_addr;
    logic [C_CACHE_DATA_WIDTH+TAG_W-1:0]   c_wr_data;
    logic                                  mem_req_valid;
    logic                                  mem_req_ready;
    logic [C_CACHE_MEM_ADDR_WIDTH-1:0]     mem_req_addr;
    logic                                  mem_rsp_valid;
    logic [C_CACHE_DATA_WIDTH-1:0]         mem_rsp_data;
    modport master (
        input  req_valid, req_addr, rsp_ready, c_rd_result, c_rd_dout, c_rd_valid,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output req_ready, rsp_valid, rsp_data, rsp_hit, c_rd_en, c_rd_addr, c_rd_din,
               c_wr_en, c_wr_addr, c_wr_data, mem_req_valid, mem_req_addr
    );
    modport slave (
        output req_valid, req_addr, rsp_ready, c_rd_result, c_rd_dout, c_rd_valid,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  req_ready, rsp_valid, rsp_data, rsp_hit, c_rd_en, c_rd_addr, c_rd_din,
               c_wr_en, c_wr_addr, c_wr_data, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/hcache_lookup_ctrl.sv
// hcache_lookup_ctrl: single-outstanding lookup front end; serves hits from the cache read port,
// refills misses from backing memory, and keeps saturating hit/miss counters.
module hcache_lookup_ctrl #(
    parameter int C_CACHE_MEM_ADDR_WIDTH = 32,
    parameter int C_CACHE_ADDR_WIDTH     = 13,
    parameter int C_CACHE_DATA_WIDTH     = 64,
    parameter int C_CNT_WIDTH            = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    hcache_lookup_if.master        bus,
    output logic [C_CNT_WIDTH-1:0] hit_cnt,
    output logic [C_CNT_WIDTH-1:0] miss_cnt
);
    typedef enum logic [2:0] {IDLE, LOOKUP, WAIT, MREQ, MWAIT, FILL, RESP} state_t;
    state_t                            state;
    logic [C_CACHE_MEM_ADDR_WIDTH-1:0] addr;
    assign bus.c_rd_addr    = addr[C_CACHE_ADDR_WIDTH-1:0];
    assign bus.c_wr_addr    = addr[C_CACHE_ADDR_WIDTH-1:0];
    assign bus.c_rd_din     = addr[C_CACHE_MEM_ADDR_WIDTH-1:C_CACHE_ADDR_WIDTH];
    assign bus.mem_req_addr = addr;
    // the refill data is parked in rsp_data so the write and the later response share one register
    assign bus.c_wr_data    = {bus.rsp_data, addr[C_CACHE_MEM_ADDR_WIDTH-1:C_CACHE_ADDR_WIDTH]};
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            addr              <= '0;
            bus.req_ready     <= 1'b1;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_data      <= '0;
            bus.rsp_hit       <= 1'b0;
            bus.c_rd_en       <= 1'b0;
            bus.c_wr_en       <= 1'b0;
            bus.mem_req_valid <= 1'b0;
            hit_cnt           <= '0;
            miss_cnt          <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    addr          <= bus.req_addr;
                    bus.req_ready <= 1'b0;
                    bus.c_rd_en   <= 1'b1;
                    state         <= LOOKUP;
                end
                LOOKUP: begin
                    bus.c_rd_en <= 1'b0;
                    state       <= WAIT;
                end
                WAIT: if (bus.c_rd_valid) begin
                    if (bus.c_rd_result) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= bus.c_rd_dout;
                        bus.rsp_hit   <= 1'b1;
                        hit_cnt       <= hit_cnt + C_CNT_WIDTH'(~&hit_cnt);
                        state         <= RESP;
                    end else begin
                        bus.mem_req_valid <= 1'b1;
                        miss_cnt          <= miss_cnt + C_CNT_WIDTH'(~&miss_cnt);
                        state             <= MREQ;
                    end
                end
                MREQ: if (bus.mem_req_ready) begin
                    bus.mem_req_valid <= 1'b0;
                    state             <= MWAIT;
                end
                MWAIT: if (bus.mem_rsp_valid) begin
                    bus.rsp_data <= bus.mem_rsp_data;
                    bus.c_wr_en  <= 1'b1;
                    state        <= FILL;
                end
                FILL: begin
                    bus.c_wr_en   <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_hit   <= 1'b0;
                    state         <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hcache_lookup_ctrl.sv
// tb_hcache_lookup_ctrl: cache/memory environment plus transaction-level reference model;
// a second instance with 2-bit counters shares all inputs to exercise saturation.
module tb_hcache_lookup_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    hcache_lookup_if b ();
    hcache_lookup_if b2 ();
    logic [31:0] hc, mc;
    logic [1:0]  hc2, mc2;
    hcache_lookup_ctrl dut (.clk(clk), .rst(rst), .bus(b.master), .hit_cnt(hc), .miss_cnt(mc));
    hcache_lookup_ctrl #(.C_CNT_WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.master), .hit_cnt(hc2), .miss_cnt(mc2));
    assign b2.req_valid     = b.req_valid;
    assign b2.req_addr      = b.req_addr;
    assign b2.rsp_ready     = b.rsp_ready;
    assign b2.c_rd_result   = b.c_rd_result;
    assign b2.c_rd_dout     = b.c_rd_dout;
    assign b2.c_rd_valid    = b.c_rd_valid;
    assign b2.mem_req_ready = b.mem_req_ready;
    assign b2.mem_rsp_valid = b.mem_rsp_valid;
    assign b2.mem_rsp_data  = b.mem_rsp_data;
    int checks = 0, errors = 0, cyc = 0;
    bit noise_en = 0;
    logic [31:0] cur_addr = '0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
        end
    endtask
    function automatic logic [63:0] mem_val(input logic [31:0] a);
        return a == 32'h2005 ? 64'hDEAD_BEEF_0000_0001 : {a ^ 32'hA5A5_0F0F, a * 32'h9E37_79B1};
    endfunction
    // two-cycle cache RAM with optional spurious result pulses while no real read is in flight
    bit cv [8192];
    bit [18:0] ct [8192];
    bit [63:0] cd [8192];
    bit s1_v, s1_h, s2_v, s2_h, nz;
    bit [63:0] s1_d, s2_d, nz_d;
    always @(posedge clk) begin
        s1_v <= b.c_rd_en;
        s1_h <= cv[b.c_rd_addr] && ct[b.c_rd_addr] == b.c_rd_din;
        s1_d <= cd[b.c_rd_addr];
        s2_v <= s1_v; s2_h <= s1_h; s2_d <= s1_d;
        nz   <= noise_en && !b.c_rd_en && !s1_v && $urandom_range(3) == 0;
        nz_d <= {$urandom, $urandom};
        if (b.c_wr_en) begin
            cv[b.c_wr_addr] <= 1'b1;
            ct[b.c_wr_addr] <= b.c_wr_data[18:0];
            cd[b.c_wr_addr] <= b.c_wr_data[82:19];
        end
    end
    assign b.c_rd_valid  = s2_v | nz;
    assign b.c_rd_result = s2_v ? s2_h : 1'b1;
    assign b.c_rd_dout   = s2_v ? s2_d : nz_d;
    // backing memory: ready after rdy_dly waiting cycles, data rsp_lat+1 cycles after the handshake
    int rdy_dly = 0, rsp_lat = 0, wcnt = 0, rcnt = 0;
    bit pend = 0;
    logic [31:0] paddr;
    assign b.mem_req_ready = b.mem_req_valid && wcnt >= rdy_dly;
    always @(posedge clk) begin
        wcnt <= (b.mem_req_valid && !b.mem_req_ready) ? wcnt + 1 : 0;
        b.mem_rsp_valid <= 1'b0;
        if (b.mem_req_valid && b.mem_req_ready) begin
            pend <= 1; rcnt <= rsp_lat; paddr <= b.mem_req_addr;
        end else if (pend) begin
            if (rcnt == 0) begin
                b.mem_rsp_valid <= 1'b1; b.mem_rsp_data <= mem_val(paddr); pend <= 0;
            end else rcnt <= rcnt - 1;
        end else if (noise_en && $urandom_range(3) == 0) begin
            b.mem_rsp_valid <= 1'b1; b.mem_rsp_data <= {$urandom, $urandom};
        end
    end
    int wr_seen = 0, rsp_seen = 0, mreq_len = 0;
    logic [12:0] wr_a = '0;
    logic [82:0] wr_d = '0;
    always @(posedge clk) begin
        if (!rst) begin
            chk("rd_wr_excl", b.c_rd_en & b.c_wr_en, 1'b0);
            if (b.mem_req_valid) chk("mem_addr_stable", b.mem_req_addr, cur_addr);
        end
        if (b.c_wr_en) begin wr_seen <= wr_seen + 1; wr_a <= b.c_wr_addr; wr_d <= b.c_wr_data; end
        if (b.rsp_valid) rsp_seen <= rsp_seen + 1;
        if (b.mem_req_valid) mreq_len <= mreq_len + 1;
    end
    // reference model: direct-mapped cache contents and counters per transaction
    bit mv [8192];
    bit [18:0] mt [8192];
    bit [63:0] md [8192];
    int m_hit = 0, m_miss = 0;
    function automatic int sat3(input int v);
        return v > 3 ? 3 : v;
    endfunction
    task automatic model(input logic [31:0] a, output bit hit, output logic [63:0] d);
        hit = mv[a[12:0]] && mt[a[12:0]] == a[31:13];
        if (hit) begin d = md[a[12:0]]; m_hit++; end
        else begin
            d = mem_val(a); m_miss++;
            mv[a[12:0]] = 1; mt[a[12:0]] = a[31:13]; md[a[12:0]] = d;
        end
    endtask
    task automatic do_req(input logic [31:0] a, input int hold, output bit gh, output logic [63:0] gd);
        bit eh;
        logic [63:0] ed;
        int t0, w0, n;
        model(a, eh, ed);
        w0 = wr_seen;
        n = 0;
        @(negedge clk);
        while (!b.req_ready && n < 200) begin @(negedge clk); n++; end
        chk("req_ready_idle", b.req_ready, 1'b1);
        cur_addr = a; b.req_valid = 1'b1; b.req_addr = a; t0 = cyc;
        @(negedge clk);
        b.req_valid = 1'b0; b.req_addr = $urandom;
        chk("req_ready_busy", b.req_ready, 1'b0);
        n = 0;
        while (!b.rsp_valid && n < 300) begin @(negedge clk); n++; end
        chk("rsp_valid", b.rsp_valid, 1'b1);
        if (eh) chk("hit_latency", cyc - t0, 4);
        gh = b.rsp_hit; gd = b.rsp_data;
        chk("rsp_data", b.rsp_data, ed);
        chk("rsp_hit", b.rsp_hit, eh);
        chk("hit_cnt", hc, m_hit);
        chk("miss_cnt", mc, m_miss);
        chk("hit_cnt_sat", hc2, sat3(m_hit));
        chk("miss_cnt_sat", mc2, sat3(m_miss));
        chk("refill_count", wr_seen - w0, eh ? 0 : 1);
        if (!eh) chk("refill_line", {wr_a, wr_d}, {a[12:0], ed, a[31:13]});
        repeat (hold) begin
            @(negedge clk);
            chk("rsp_hold", {b.rsp_valid, b.rsp_hit, b.req_ready, b.rsp_data}, {1'b1, eh, 1'b0, ed});
        end
        b.rsp_ready = 1'b1;
        @(negedge clk);
        b.rsp_ready = 1'b0;
        chk("rsp_release", {b.rsp_valid, b.req_ready}, 2'b01);
    endtask
    typedef struct { logic [31:0] a; bit eh; logic [63:0] ed; } vec_t;
    vec_t tbl [8];
    initial begin
        bit gh;
        logic [63:0] gd;
        int n, w0, r0;
        tbl[0] = '{32'h0000_2005, 1'b0, 64'hDEAD_BEEF_0000_0001};
        tbl[1] = '{32'h0000_2005, 1'b1, 64'hDEAD_BEEF_0000_0001};
        tbl[2] = '{32'h0000_4005, 1'b0, mem_val(32'h0000_4005)};
        tbl[3] = '{32'h0000_2005, 1'b0, 64'hDEAD_BEEF_0000_0001};
        for (int i = 4; i < 8; i++) tbl[i] = '{32'h0000_2005, 1'b1, 64'hDEAD_BEEF_0000_0001};
        b.req_valid = 0; b.req_addr = '0; b.rsp_ready = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {b.req_ready, b.rsp_valid, b.c_rd_en, b.c_wr_en, b.mem_req_valid}, 5'b10000);
        chk("reset_counters", {hc, mc}, 64'h0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_req(tbl[i].a, i % 3, gh, gd);
            chk("tbl_hit", gh, tbl[i].eh);
            chk("tbl_data", gd, tbl[i].ed);
            if (!tbl[i].eh) chk("tbl_refill", {wr_a, wr_d}, {tbl[i].a[12:0], tbl[i].ed, tbl[i].a[31:13]});
        end
        chk("tbl_totals", {hc, mc, hc2, mc2}, {32'd5, 32'd3, 2'd3, 2'd3});
        // slow memory handshake and a long-stalled consumer
        rdy_dly = 5; mreq_len = 0;
        do_req(32'h0000_6006, 10, gh, gd);
        chk("mreq_hold_len", mreq_len, 6);
        noise_en = 1;
        for (int i = 0; i < 40; i++) begin
            rdy_dly = $urandom_range(3); rsp_lat = $urandom_range(3);
            do_req({19'($urandom_range(3)), ($urandom_range(3) == 0) ? 13'h1FFF : 13'($urandom_range(3))},
                   $urandom_range(2), gh, gd);
        end
        // reset while waiting for memory; the late data must not refill or respond
        noise_en = 0; rdy_dly = 0; rsp_lat = 10;
        @(negedge clk);
        cur_addr = 32'h0A0A_1234; b.req_valid = 1'b1; b.req_addr = cur_addr;
        @(negedge clk);
        b.req_valid = 1'b0;
        n = 0;
        while (!pend && n < 100) begin @(negedge clk); n++; end
        chk("reached_mwait", pend, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        w0 = wr_seen; r0 = rsp_seen;
        repeat (20) @(negedge clk);
        chk("rst_no_refill", wr_seen - w0, 0);
        chk("rst_no_rsp", rsp_seen - r0, 0);
        chk("rst_idle", {b.req_ready, b.rsp_valid, b.mem_req_valid}, 3'b100);
        chk("rst_counters", {hc, mc, hc2, mc2}, 68'h0);
        m_hit = 0; m_miss = 0; rsp_lat = 1;
        do_req(32'h0A0A_1234, 0, gh, gd);
        do_req(32'h0A0A_1234, 1, gh, gd);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
